// File: rtl/display_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : display_scan_mux_pkg
// Brief  : Shared display constants and types for the 7-segment scan mux.
// Rev    : 1.0  initial release
// ============================================================================
package display_scan_mux_pkg;

  // Width of one hex digit as seen by the segment decoder
  localparam int NIBBLE_W = 4;

  // Anode enables are active-low: a 1 on every bit turns all digits off
  localparam logic ANODE_OFF_BIT = 1'b1;

  // Decimal point is active-low
  localparam logic DP_OFF = 1'b1;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage : display_scan_mux_pkg
`default_nettype wire

// File: rtl/display_scan_mux_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module : scan_tick_gen
// Brief  : Digit-slot prescaler. Counts 0..DIV-1, flags the last cycle of a
//          slot and the dead-time window at the start of each slot.
// Rev    : 1.0  initial release
// ============================================================================
module scan_tick_gen #(
  parameter int DIV  = 50000,
  parameter int DEAD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [$clog2(DIV)-1:0]  o_cnt,
  output logic                    o_slot_end,
  output logic                    o_dead
);

  localparam int                CNT_W  = $clog2(DIV);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running slot counter, wraps after DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == c_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_slot_end = (r_cnt == c_LAST);

  // With no dead time the comparison would be constant-false, so tie it off
  generate
    if (DEAD == 0) begin : g_no_dead
      assign o_dead = 1'b0;
    end else begin : g_dead
      localparam logic [CNT_W-1:0] c_DEAD = CNT_W'(DEAD);
      assign o_dead = (r_cnt < c_DEAD);
    end
  endgenerate

endmodule : scan_tick_gen
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module : display_scan_mux
// Brief  : Time-multiplexes an N_DIG-digit hex value onto one shared 7-segment
//          driver with frame-coherent latching, anti-ghosting dead time and
//          leading-zero blanking. All outputs are registered.
// Rev    : 1.0  initial release
// ============================================================================
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int N_DIG = 4,
  parameter int DIV   = 50000,
  parameter int DEAD  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NIBBLE_W*N_DIG-1:0] value,
  input  logic [N_DIG-1:0]          dp_in,
  input  logic                      blank_lead,
  output logic [N_DIG-1:0]          an,
  output logic [NIBBLE_W-1:0]       digit,
  output logic                      dp,
  output logic                      blank,
  output logic                      frame_tick
);

  localparam int                  IDX_W      = $clog2(N_DIG);
  localparam int                  CNT_W      = $clog2(DIV);
  localparam logic [IDX_W-1:0]    c_IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [N_DIG-1:0]    c_AN_OFF   = {N_DIG{ANODE_OFF_BIT}};

  // Reject parameter sets the scan timing cannot support
  generate
    if (N_DIG < 2 || DIV < 2 || DEAD < 0 || DEAD >= DIV) begin : g_bad_params
      $error("display_scan_mux: need N_DIG>=2, DIV>=2, 0<=DEAD<DIV");
    end
  endgenerate

  logic [CNT_W-1:0]           w_cnt;
  logic                       w_slot_end;
  logic                       w_dead;
  logic                       w_frame_end;

  logic [IDX_W-1:0]           r_idx;
  logic [NIBBLE_W*N_DIG-1:0]  r_sh_value;
  logic [N_DIG-1:0]           r_sh_dp;
  logic                       r_sh_blank_lead;

  logic [N_DIG-1:0]           w_lz;
  logic                       w_zero_run;
  logic [N_DIG-1:0]           w_an_sel;
  nibble_t                    w_nib;
  logic                       w_lz_cur;
  logic                       w_dp_cur;

  logic [N_DIG-1:0]           r_an;
  nibble_t                    r_digit;
  logic                       r_dp;
  logic                       r_blank;
  logic                       r_frame_tick;

  scan_tick_gen #(
    .DIV  (DIV),
    .DEAD (DEAD)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .o_cnt      (w_cnt),
    .o_slot_end (w_slot_end),
    .o_dead     (w_dead)
  );

  // Last cycle of the last digit slot closes the frame
  assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);

  // Digit index advances once per slot and wraps with the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Shadows reload only at frame boundaries so a frame never shows mixed values
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_value      <= '0;
      r_sh_dp         <= '0;
      r_sh_blank_lead <= 1'b0;
    end else if (w_frame_end) begin
      r_sh_value      <= value;
      r_sh_dp         <= dp_in;
      r_sh_blank_lead <= blank_lead;
    end
  end

  // Leading-zero map: digit k blanks when it and all digits above it are zero;
  // digit 0 always shows so an all-zero value still displays a single '0'
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_sh_value[k*NIBBLE_W +: NIBBLE_W] == '0);
      w_lz[k]    = r_sh_blank_lead && (k != 0) && w_zero_run;
    end
  end

  // One-cold anode pattern for the current digit index
  always_comb begin
    w_an_sel = c_AN_OFF;
    for (int k = 0; k < N_DIG; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_an_sel[k] = ~ANODE_OFF_BIT;
      end
    end
  end

  assign w_nib    = r_sh_value[{r_idx, 2'b00} +: NIBBLE_W];
  assign w_lz_cur = w_lz[r_idx];
  assign w_dp_cur = r_sh_dp[r_idx];

  // Output register: dead time and blanked digits both keep every anode off
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= c_AN_OFF;
      r_digit      <= '0;
      r_dp         <= DP_OFF;
      r_blank      <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_digit      <= w_nib;
      r_frame_tick <= w_frame_end;
      if (w_dead || w_lz_cur) begin
        r_an    <= c_AN_OFF;
        r_dp    <= DP_OFF;
        r_blank <= 1'b1;
      end else begin
        r_an    <= w_an_sel;
        r_dp    <= ~w_dp_cur;
        r_blank <= 1'b0;
      end
    end
  end

  assign an         = r_an;
  assign digit      = r_digit;
  assign dp         = r_dp;
  assign blank      = r_blank;
  assign frame_tick = r_frame_tick;

endmodule : display_scan_mux
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_display_scan_mux
// Brief  : Self-checking bench for display_scan_mux (N_DIG=4, DIV=8, DEAD=2).
//          Expected outputs come from edge-count arithmetic: slot position,
//          digit index and frame number are derived from the number of
//          clock edges since reset release.
// Rev    : 1.0  initial release
// ============================================================================
module tb_display_scan_mux;

  localparam int N_DIG = 4;
  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = N_DIG * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lead;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dp;
  logic        blank;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scan_mux #(
    .N_DIG (N_DIG),
    .DIV   (DIV),
    .DEAD  (DEAD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lead (blank_lead),
    .an         (an),
    .digit      (digit),
    .dp         (dp),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  // Reference model: {an, digit, dp, blank, frame_tick} expected after each edge
  int          m_edges;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_bl;
  logic [10:0] exp_out;

  always @(posedge clk) begin
    int          pos;
    int          k;
    logic [3:0]  e_an;
    logic [3:0]  e_dig;
    logic        e_dp;
    logic        e_blank;
    logic        e_ft;
    logic        lz;
    if (rst) begin
      m_edges = 0;
      m_val   = 16'h0;
      m_dp    = 4'h0;
      m_bl    = 1'b0;
      exp_out = {4'hF, 4'h0, 1'b1, 1'b0, 1'b0};
    end else begin
      pos   = m_edges % DIV;
      k     = (m_edges / DIV) % N_DIG;
      e_dig = 4'((m_val >> (4 * k)) & 16'hF);
      lz    = m_bl && (k != 0) && ((m_val >> (4 * k)) == 16'h0);
      if (pos < DEAD) begin
        e_an = 4'hF; e_dp = 1'b1; e_blank = 1'b1;
      end else if (lz) begin
        e_an = 4'hF; e_dp = 1'b1; e_blank = 1'b1;
      end else begin
        e_an = ~(4'b0001 << k); e_dp = ~m_dp[k]; e_blank = 1'b0;
      end
      e_ft    = ((m_edges % FRAME) == FRAME - 1);
      exp_out = {e_an, e_dig, e_dp, e_blank, e_ft};
      if ((m_edges % FRAME) == FRAME - 1) begin
        m_val = value;
        m_dp  = dp_in;
        m_bl  = blank_lead;
      end
      m_edges = m_edges + 1;
    end
  end

  task automatic test_reset();
    rst = 1'b1; value = 16'hBEEF; dp_in = 4'hF; blank_lead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({an, dp, blank, frame_tick} !== {4'b1111, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset: an=%b dp=%b blank=%b ft=%b, want an=1111 dp=1 blank=0 ft=0",
                 an, dp, blank, frame_tick);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < DIV; i++) begin
      @(negedge clk);
      checks++;
      if (digit !== 4'h0 || {an, digit, dp, blank, frame_tick} !== exp_out) begin
        errors++;
        $display("FAIL first_slot: got %b want %b (digit must be 0)",
                 {an, digit, dp, blank, frame_tick}, exp_out);
      end
    end
  endtask

  task automatic test_digits();
    int dead_cnt;
    value = 16'h12A4; dp_in = 4'h0; blank_lead = 1'b0;
    dead_cnt = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (an == 4'hF) dead_cnt++;
      checks++;
      if ({an, digit, dp, blank, frame_tick} !== exp_out) begin
        errors++;
        $display("FAIL digits_12A4: got %b want %b", {an, digit, dp, blank, frame_tick}, exp_out);
      end
    end
    checks++;
    if (dead_cnt !== 3 * N_DIG * DEAD) begin
      errors++;
      $display("FAIL dead_time_count: got %0d want %0d", dead_cnt, 3 * N_DIG * DEAD);
    end
  endtask

  task automatic test_leading_zero();
    value = 16'h0050; dp_in = 4'hF; blank_lead = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, digit, dp, blank, frame_tick} !== exp_out) begin
        errors++;
        $display("FAIL lz_0050: got %b want %b", {an, digit, dp, blank, frame_tick}, exp_out);
      end
    end
    value = 16'h0000;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, digit, dp, blank, frame_tick} !== exp_out) begin
        errors++;
        $display("FAIL lz_0000: got %b want %b", {an, digit, dp, blank, frame_tick}, exp_out);
      end
    end
  endtask

  task automatic test_tearing();
    int ticks;
    value = 16'h1111; dp_in = 4'h0; blank_lead = 1'b0;
    ticks = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (frame_tick) ticks++;
      if (i == FRAME + FRAME / 2) value = 16'h2222;
      checks++;
      if ({an, digit, dp, blank, frame_tick} !== exp_out) begin
        errors++;
        $display("FAIL tearing: got %b want %b", {an, digit, dp, blank, frame_tick}, exp_out);
      end
    end
    checks++;
    if (ticks !== 4) begin
      errors++;
      $display("FAIL frame_tick_rate: got %0d ticks want 4", ticks);
    end
  endtask

  task automatic test_dp();
    value = 16'h9876; dp_in = 4'b0100; blank_lead = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, digit, dp, blank, frame_tick} !== exp_out) begin
        errors++;
        $display("FAIL dp_0100: got %b want %b", {an, digit, dp, blank, frame_tick}, exp_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, digit, dp, blank, frame_tick} !== exp_out) begin
        errors++;
        $display("FAIL random: got %b want %b", {an, digit, dp, blank, frame_tick}, exp_out);
      end
      if ($urandom_range(0, 19) == 0) begin
        value = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
        dp_in = 4'($urandom);
        blank_lead = 1'($urandom);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    int guard;
    value = 16'h4321; dp_in = 4'h0; blank_lead = 1'b0;
    guard = 0;
    // Align so that the state seen by the next edge is cnt=5, idx=2
    while ((m_edges % FRAME) != 2 * DIV + 5 && guard < 2 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 2 * FRAME) begin
      errors++;
      $display("FAIL mid_reset_align: alignment not reached in %0d cycles", guard);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, digit, dp, blank, frame_tick} !== {4'b1111, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got %b want 11110000100", {an, digit, dp, blank, frame_tick});
    end
    rst = 1'b0;
    for (int i = 0; i < FRAME + DIV; i++) begin
      @(negedge clk);
      checks++;
      if ({an, digit, dp, blank, frame_tick} !== exp_out) begin
        errors++;
        $display("FAIL mid_reset_restart: got %b want %b", {an, digit, dp, blank, frame_tick}, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_leading_zero();
    test_tearing();
    test_dp();
    test_random();
    test_reset_mid_slot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_display_scan_mux
`default_nettype wire
